// File: rtl/mips_pipe_stage_chain.sv
// Parametrised chain of MIPS inter-stage registers with per-stage valid, stall, bubble and flush.
// Optional macro PIPE_PERF_COUNTERS_EN adds saturating stall/flush/retire counters.
module mips_pipe_stage_chain #(
   parameter int NBits     = 32,
   parameter int STAGES    = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NBits-1:0]          in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [STAGES-1:0]         stall_req,
   input  logic [STAGES-1:0]         flush_req,
   output logic [STAGES*NBits-1:0]   stage_data,
   output logic [STAGES-1:0]         stage_valid,
   output logic [NBits-1:0]          out_data,
   output logic                      out_valid
`ifdef PIPE_PERF_COUNTERS_EN
   ,
   output logic [CNT_WIDTH-1:0]      stall_cycles,
   output logic [CNT_WIDTH-1:0]      flush_events,
   output logic [CNT_WIDTH-1:0]      retired
`endif
);

   logic [NBits-1:0]  data_q  [STAGES];
   logic [NBits-1:0]  data_d  [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] hold;
   logic [STAGES-1:0] kill;

   // A stall or flush at stage i reaches every stage upstream of it.
   always_comb begin
      logic hold_acc;
      logic kill_acc;
      hold     = '0;
      kill     = '0;
      hold_acc = 1'b0;
      kill_acc = 1'b0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         hold_acc = hold_acc | stall_req[i];
         kill_acc = kill_acc | flush_req[i];
         hold[i]  = hold_acc;
         kill[i]  = kill_acc;
      end
   end

   assign in_ready = reset | ~hold[0];

   always_comb begin
      int prev;
      for (int i = 0; i < STAGES; i++) begin
         prev       = (i == 0) ? 0 : i - 1;
         data_d[i]  = data_q[i];
         valid_d[i] = valid_q[i];
         if (kill[i]) begin
            data_d[i]  = '0;
            valid_d[i] = 1'b0;
         end else if (hold[i]) begin
            data_d[i]  = data_q[i];
            valid_d[i] = valid_q[i];
         end else if (i == 0) begin
            data_d[i]  = in_valid ? in_data : '0;
            valid_d[i] = in_valid;
         end else if (hold[prev]) begin
            data_d[i]  = '0;
            valid_d[i] = 1'b0;
         end else begin
            data_d[i]  = data_q[prev];
            valid_d[i] = valid_q[prev];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= data_d[i];
         end
         valid_q <= valid_d;
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_flat
      assign stage_data[g*NBits +: NBits] = data_q[g];
   end

   assign stage_valid = valid_q;
   assign out_data    = data_q[STAGES-1];
   assign out_valid   = valid_q[STAGES-1];

`ifdef PIPE_PERF_COUNTERS_EN
   logic [CNT_WIDTH-1:0] stall_cycles_q;
   logic [CNT_WIDTH-1:0] flush_events_q;
   logic [CNT_WIDTH-1:0] retired_q;

   // All three counters saturate at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
         retired_q      <= '0;
      end else begin
         if (hold[0] && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + 1'b1;
         end
         if ((|flush_req) && (flush_events_q != '1)) begin
            flush_events_q <= flush_events_q + 1'b1;
         end
         if (valid_q[STAGES-1] && !hold[STAGES-1] && (retired_q != '1)) begin
            retired_q <= retired_q + 1'b1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
   assign retired      = retired_q;
`endif

endmodule

// File: doc/mips_pipe_stage_chain.md
Name: mips_pipe_stage_chain

Overview:
- Parametrised chain of pipeline registers for the MIPS datapath, for example IF/ID through MEM/WB, with per-stage valid bits.
- Supports per-stage stall with upstream propagation, bubble insertion, and per-stage flush.
- Generalises the fixed single-purpose inter-stage registers to any number of stages and any payload width.
- Invalid slots always carry NOP (all zeros), so downstream decode sees a harmless instruction.

Parameters:
- NBits, 32, payload width per stage.
- STAGES, 4, number of register stages; legal range 1..8.
- CNT_WIDTH, 16, performance counter width (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NBits  payload presented to stage 0.
- in_valid  input  1  in_data is meaningful this cycle.
- in_ready  output  1  stage 0 accepts the input this cycle.
- stall_req  input  STAGES  bit i: stage i must hold its contents.
- flush_req  input  STAGES  bit i: kill stages 0..i.
- stage_data  output  STAGES*NBits  flattened register contents; stage i is at bits [i*NBits +: NBits].
- stage_valid  output  STAGES  valid bit of each stage.
- out_data  output  NBits  equals stage STAGES-1 data.
- out_valid  output  1  equals stage STAGES-1 valid.

Behaviour:
- Reset (synchronous, active-high): at the clock edge with reset=1, all data registers are set to 0 and all valid bits to 0.
  - reset overrides stall and flush.
  - in_ready is combinational and evaluates to 1 while reset is asserted.
- Hold vector: hold[i] = OR(stall_req[j]) for j = i..STAGES-1. A stall freezes its own stage and everything upstream of it.
- in_ready = !hold[0].
- Flush mask: kill[i] = OR(flush_req[j]) for j = i..STAGES-1.
- Per-stage update at each clock edge, first matching rule wins:
  1. kill[i] → data[i]=0, valid[i]=0. Flush beats stall.
  2. hold[i] → data[i] and valid[i] unchanged.
  3. i>0 and hold[i-1] → bubble: data[i]=0, valid[i]=0.
  4. i>0 → data[i]=data[i-1], valid[i]=valid[i-1].
  5. i=0 → data[0] = in_valid ? in_data : 0, valid[0] = in_valid.
- Latency: STAGES cycles from input acceptance to out_valid, when there are no stalls.
- Throughput: 1 item per cycle.
- An input presented while in_ready=0 is not captured; the source must hold it.
- An input presented in a cycle where kill[0]=1 is discarded, even though in_ready may be 1.
- Simultaneous events:
  - stall_req[k] together with flush_req[m], m>=k: stages 0..m are cleared; stages m+1..k hold.
  - stall_req[k] together with flush_req[m], m<k: stages 0..m are cleared; stages m+1..k hold; stage k+1 takes a bubble.
- Stall released: movement resumes on the next edge. No item is lost or duplicated.
- Reset mid-stall or mid-flush: reset wins and the chain is empty on the following cycle.
- STAGES=1: stage 0 is also the output stage; rules 1, 2 and 5 apply.
- No combinational path from stall_req or flush_req to out_data or out_valid.

Optional Feature:
- Macro: PIPE_PERF_COUNTERS_EN.
- When defined, three extra outputs exist, each CNT_WIDTH wide, each saturating at all-ones, each cleared by reset:
  - stall_cycles: increments on any cycle where hold[0]=1.
  - flush_events: increments on any cycle where any flush_req bit is 1 (one count per cycle, not per bit).
  - retired: increments on each cycle where out_valid=1 and hold[STAGES-1]=0.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Free flow, STAGES=4: feed 0x11, 0x22, 0x33, 0x44 on consecutive cycles with in_valid=1 → out_data shows 0x11 on cycle 4, then 0x22, 0x33, 0x44 on the following cycles; out_valid=1 throughout that window.
- Stall with bubble: set stall_req[1]=1 for 2 cycles while a stream flows → in_ready=0 for both cycles; stages 0 and 1 hold; stage 2 receives 2 invalid zero slots; every item arrives at the output exactly once, in order.
- Flush: stages hold A, B, C, D (stage 0 to 3); pulse flush_req[2]=1 with in_valid=1 and in_data=E → next cycle stage_valid=4'b1000; E is not captured; stages 0..2 data = 0.
- Flush plus stall: stall_req[3]=1 and flush_req[1]=1 in the same cycle → stages 0 and 1 cleared; stages 2 and 3 keep their data and valid bits.
- Reset mid-operation: assert reset for 1 cycle with the chain full and stall_req=4'b1111 → next cycle all stage_valid=0, all data=0, in_ready=1.
- With PIPE_PERF_COUNTERS_EN and CNT_WIDTH=4: hold stall_req[0]=1 for 20 cycles → stall_cycles saturates at 4'hF; flush_events and retired remain 0.
